// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS fetch front end.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] PC_INCR   = 32'd4;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } fetch_word_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory fetch port shared by the fetch stage and the memory model.
interface if_fetch_stage_if;
  // Handshake: a word transfers on any cycle where imem_req and imem_ready are
  // both high. imem_ready low with imem_req high is a wait state; the fetch
  // stage keeps imem_addr stable until the word arrives or it is redirected.
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_addr,
    output imem_req,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_stage_next_pc_mux.sv
// Combinational next-PC selection, in reset > redirect > flush > release > advance order.
module next_pc_mux (
  input  logic        reset,
  input  logic        redirect,
  input  logic        flush,
  input  logic        use_buf,
  input  logic        advance,
  input  logic [31:0] reset_pc,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] buf_pc_plus4,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_next
);

  always_comb begin
    pc_next = pc_cur;
    if (reset) begin
      pc_next = reset_pc;
    end else if (redirect) begin
      pc_next = redirect_pc;
    end else if (flush) begin
      // The word fetched this cycle is dropped, so fetch the same PC again.
      pc_next = pc_cur;
    end else if (use_buf) begin
      pc_next = buf_pc_plus4;
    end else if (advance) begin
      pc_next = pc_plus4;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: next-PC generation, IF/ID register and one-entry hold buffer.
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              pc_cur,
  output logic [31:0]              pc_next,
  if_fetch_stage_if.master         imem,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic [31:0]              id_instr,
  output logic [31:0]              id_pc_plus4,
  output logic                     id_valid,
  output logic [0:0]               dbg_state
);

  localparam logic [0:0] S_FETCH = FETCH;
  localparam logic [0:0] S_HOLD  = HOLD;

  logic [0:0]  state;
  fetch_word_t hold_buf;
  logic [31:0] pc_plus4;
  logic        in_fetch;
  logic        take_word;
  logic        park_word;
  logic        release_buf;

  assign pc_plus4    = pc_cur + PC_INCR;
  assign in_fetch    = (state == S_FETCH);
  assign take_word   = in_fetch & imem.imem_ready & ~stall;
  assign park_word   = in_fetch & imem.imem_ready & stall;
  assign release_buf = ~in_fetch & ~stall;

  assign imem.imem_addr = pc_cur;
  assign imem.imem_req  = ~reset & in_fetch;
  assign dbg_state      = state;

  next_pc_mux u_next_pc_mux (
    .reset        (reset),
    .redirect     (redirect),
    .flush        (flush),
    .use_buf      (release_buf),
    .advance      (take_word),
    .reset_pc     (RESET_PC),
    .redirect_pc  (redirect_pc),
    .buf_pc_plus4 (hold_buf.pc_plus4),
    .pc_plus4     (pc_plus4),
    .pc_cur       (pc_cur),
    .pc_next      (pc_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_FETCH;
      hold_buf    <= '{instr: NOP_INSTR, pc_plus4: 32'h0};
      id_instr    <= NOP_INSTR;
      id_pc_plus4 <= 32'h0;
      id_valid    <= 1'b0;
    end else if (redirect || flush) begin
      // Bubble keeps the old pc_plus4; only instr and valid are cleared.
      state       <= S_FETCH;
      hold_buf    <= '{instr: NOP_INSTR, pc_plus4: 32'h0};
      id_instr    <= NOP_INSTR;
      id_valid    <= 1'b0;
    end else if (in_fetch) begin
      if (take_word) begin
        id_instr    <= imem.imem_rdata;
        id_pc_plus4 <= pc_plus4;
        id_valid    <= 1'b1;
      end else if (park_word) begin
        hold_buf <= '{instr: imem.imem_rdata, pc_plus4: pc_plus4};
        state    <= S_HOLD;
      end else if (!stall) begin
        id_instr <= NOP_INSTR;
        id_valid <= 1'b0;
      end
    end else if (release_buf) begin
      id_instr    <= hold_buf.instr;
      id_pc_plus4 <= hold_buf.pc_plus4;
      id_valid    <= 1'b1;
      state       <= S_FETCH;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed table-driven bench for if_fetch_stage; the bench models the PC register.
module tb_if_fetch_stage;
  import mips_pkg::*;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic [31:0] rdata;
    logic        stl;
    logic        fl;
    logic        rd;
    logic [31:0] rpc;
    logic [31:0] e_addr;
    logic [31:0] e_next;
    logic        e_req;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic        e_state;
  } vec_t;

  localparam logic F = 1'b0;
  localparam logic H = 1'b1;
  localparam logic [31:0] NOP = 32'h0000_0000;

  // clock / reset
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_cur = 32'h0;
  logic [31:0] pc_next;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic [0:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  if_fetch_stage_if imem ();

  if_fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .pc_cur      (pc_cur),
    .pc_next     (pc_next),
    .imem        (imem.master),
    .stall       (stall),
    .flush       (flush),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_instr    (id_instr),
    .id_pc_plus4 (id_pc_plus4),
    .id_valid    (id_valid),
    .dbg_state   (dbg_state)
  );

  // PC register model fed by pc_next.
  always @(posedge clk) pc_cur <= pc_next;

  initial begin
    imem.imem_ready = 1'b0;
    imem.imem_rdata = 32'h0;
  end

  function automatic vec_t mk(
    input logic rst, input logic rdy, input logic [31:0] rdata,
    input logic stl, input logic fl, input logic rd, input logic [31:0] rpc,
    input logic [31:0] e_addr, input logic [31:0] e_next, input logic e_req,
    input logic [31:0] e_instr, input logic [31:0] e_pc4, input logic e_valid,
    input logic e_state);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rdata = rdata; v.stl = stl; v.fl = fl;
    v.rd = rd; v.rpc = rpc; v.e_addr = e_addr; v.e_next = e_next;
    v.e_req = e_req; v.e_instr = e_instr; v.e_pc4 = e_pc4;
    v.e_valid = e_valid; v.e_state = e_state;
    return v;
  endfunction

  task automatic check32(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%h expected=%h", name, idx, act, exp);
    end
  endtask

  // driver: apply one vector, check combinational outputs, then registered ones
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    reset           = v.rst;
    imem.imem_ready = v.rdy;
    imem.imem_rdata = v.rdata;
    stall           = v.stl;
    flush           = v.fl;
    redirect        = v.rd;
    redirect_pc     = v.rpc;
    #1;
    check32("imem_addr", idx, imem.imem_addr, v.e_addr);
    check32("pc_next", idx, pc_next, v.e_next);
    check32("imem_req", idx, {31'h0, imem.imem_req}, {31'h0, v.e_req});
    @(posedge clk);
    #1;
    check32("id_instr", idx, id_instr, v.e_instr);
    check32("id_pc_plus4", idx, id_pc_plus4, v.e_pc4);
    check32("id_valid", idx, {31'h0, id_valid}, {31'h0, v.e_valid});
    check32("state", idx, {31'h0, dbg_state}, {31'h0, v.e_state});
  endtask

  vec_t tbl[$];

  initial begin
    //              rst rdy rdata         stl fl rd rpc            addr          next          req instr         pc4           v  st
    tbl.push_back(mk(1, 0, 32'h0,          0, 0, 0, 32'h0,          32'h0,        32'h0,        0, NOP,          32'h0,        0, F));
    tbl.push_back(mk(1, 0, 32'h0,          0, 0, 0, 32'h0,          32'h0,        32'h0,        0, NOP,          32'h0,        0, F));
    // sequential fetch
    tbl.push_back(mk(0, 1, 32'h2001_0005,  0, 0, 0, 32'h0,          32'h0,        32'h4,        1, 32'h2001_0005, 32'h4,       1, F));
    tbl.push_back(mk(0, 1, 32'h2002_0007,  0, 0, 0, 32'h0,          32'h4,        32'h8,        1, 32'h2002_0007, 32'h8,       1, F));
    // two wait states at 8
    tbl.push_back(mk(0, 0, 32'h0,          0, 0, 0, 32'h0,          32'h8,        32'h8,        1, NOP,          32'h8,        0, F));
    tbl.push_back(mk(0, 0, 32'h0,          0, 0, 0, 32'h0,          32'h8,        32'h8,        1, NOP,          32'h8,        0, F));
    tbl.push_back(mk(0, 1, 32'h8C03_0004,  0, 0, 0, 32'h0,          32'h8,        32'hC,        1, 32'h8C03_0004, 32'hC,       1, F));
    tbl.push_back(mk(0, 1, 32'h0043_2020,  0, 0, 0, 32'h0,          32'hC,        32'h10,       1, 32'h0043_2020, 32'h10,      1, F));
    // stall on word return at 0x10, held three cycles
    tbl.push_back(mk(0, 1, 32'hAC01_0000,  1, 0, 0, 32'h0,          32'h10,       32'h10,       1, 32'h0043_2020, 32'h10,      1, H));
    tbl.push_back(mk(0, 1, 32'hDEAD_BEEF,  1, 0, 0, 32'h0,          32'h10,       32'h10,       0, 32'h0043_2020, 32'h10,      1, H));
    tbl.push_back(mk(0, 1, 32'hDEAD_BEEF,  1, 0, 0, 32'h0,          32'h10,       32'h10,       0, 32'h0043_2020, 32'h10,      1, H));
    tbl.push_back(mk(0, 1, 32'hDEAD_BEEF,  0, 0, 0, 32'h0,          32'h10,       32'h14,       0, 32'hAC01_0000, 32'h14,      1, F));
    // park again, then redirect over stall from HOLD
    tbl.push_back(mk(0, 1, 32'h1111_0014,  1, 0, 0, 32'h0,          32'h14,       32'h14,       1, 32'hAC01_0000, 32'h14,      1, H));
    tbl.push_back(mk(0, 0, 32'h0,          1, 0, 1, 32'h40,         32'h14,       32'h40,       0, NOP,          32'h14,       0, F));
    tbl.push_back(mk(0, 1, 32'h2222_0040,  0, 0, 0, 32'h0,          32'h40,       32'h44,       1, 32'h2222_0040, 32'h44,      1, F));
    // redirect drops same-cycle data, then flush at 0x20 and refetch
    tbl.push_back(mk(0, 1, 32'h3333_0044,  0, 0, 1, 32'h20,         32'h44,       32'h20,       1, NOP,          32'h44,       0, F));
    tbl.push_back(mk(0, 1, 32'h4444_0020,  0, 1, 0, 32'h0,          32'h20,       32'h20,       1, NOP,          32'h44,       0, F));
    tbl.push_back(mk(0, 1, 32'h4444_0020,  0, 0, 0, 32'h0,          32'h20,       32'h24,       1, 32'h4444_0020, 32'h24,      1, F));
    // flush wins over stall; stall alone with no data leaves IF/ID alone
    tbl.push_back(mk(0, 1, 32'h5555_0024,  1, 1, 0, 32'h0,          32'h24,       32'h24,       1, NOP,          32'h24,       0, F));
    tbl.push_back(mk(0, 0, 32'h0,          1, 0, 0, 32'h0,          32'h24,       32'h24,       1, NOP,          32'h24,       0, F));
    // wrap from 0xFFFF_FFFC
    tbl.push_back(mk(0, 0, 32'h0,          0, 0, 1, 32'hFFFF_FFFC,  32'h24,       32'hFFFF_FFFC, 1, NOP,         32'h24,       0, F));
    tbl.push_back(mk(0, 1, 32'h6666_FFFC,  0, 0, 0, 32'h0,          32'hFFFF_FFFC, 32'h0,       1, 32'h6666_FFFC, 32'h0,       1, F));
    // reset while in HOLD, then clean restart with no residue
    tbl.push_back(mk(0, 1, 32'h7777_0000,  1, 0, 0, 32'h0,          32'h0,        32'h0,        1, 32'h6666_FFFC, 32'h0,       1, H));
    tbl.push_back(mk(1, 0, 32'h0,          1, 0, 0, 32'h0,          32'h0,        32'h0,        0, NOP,          32'h0,        0, F));
    tbl.push_back(mk(0, 1, 32'h2001_0005,  0, 0, 0, 32'h0,          32'h0,        32'h4,        1, 32'h2001_0005, 32'h4,       1, F));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // back-to-back fetch after a fresh reset: one instruction per cycle
    apply(mk(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h4, 32'h0, 0, NOP, 32'h0, 0, F), 100);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] w;
      logic [31:0] a;
      w = 32'hA000_0000 | i;
      a = 32'(i) * 32'd4;
      apply(mk(0, 1, w, 0, 0, 0, 32'h0, a, a + 32'd4, 1, w, a + 32'd4, 1, F), 101 + i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
